// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and word-addressed data memory bus of the load/store unit.
// The slave modport is the unit; the master modport is the core/memory side that drives it.
interface load_store_unit_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_read;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [DATA_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  resp_valid;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  logic                  dm_memread;
  logic                  dm_memwrite;
  logic [DM_ADDRESS-1:0] dm_a;
  logic [DATA_W-1:0]     dm_wd;
  logic [DATA_W-1:0]     dm_rd;

  modport slave (
    input  req_valid, req_read, req_write, req_funct3, req_addr, req_wdata, dm_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output dm_memread, dm_memwrite, dm_a, dm_wd
  );

  modport master (
    output req_valid, req_read, req_write, req_funct3, req_addr, req_wdata, dm_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  dm_memread, dm_memwrite, dm_a, dm_wd
  );
endinterface

// File: rtl/load_store_unit.sv
// Turns RISC-V B/H/W loads and stores into whole-word data memory accesses;
// sub-word stores are read-modify-write, loads are sign/zero extended. DATA_W must be 32.
module load_store_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_RMW_RD, S_RMW_WR, S_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [DM_ADDRESS-1:0] idx_q;
  logic [1:0]            lane_q;
  logic [2:0]            f3_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;

  logic                  accept;
  logic                  ld_ok, st_ok, misal, err_req, nop_req;
  logic [DATA_W-1:0]     merged;
  logic [DATA_W-1:0]     load_ext;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;

  // Upper address bits are intentionally dropped so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.req_addr[DATA_W-1:DM_ADDRESS+2]};

  assign accept = bus.req_valid && (state_q == S_IDLE);

  always_comb begin
    ld_ok   = bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok   = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    misal   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
              ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    nop_req = !bus.req_read && !bus.req_write;
    err_req = (bus.req_read && bus.req_write) ||
              (bus.req_read  && (!ld_ok || misal)) ||
              (bus.req_write && (!st_ok || misal));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (err_req || nop_req)               state_d = S_RESP;
          else if (bus.req_read)                state_d = S_LOAD;
          else if (bus.req_funct3[1:0] == 2'b10) state_d = S_STORE;
          else                                  state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_STORE:  state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Lane extraction and merge both work off the latched byte offset.
  always_comb begin
    byte_v = bus.dm_rd[{lane_q, 3'b000} +: 8];
    half_v = bus.dm_rd[{lane_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_ext = {{(DATA_W-8){~f3_q[2] & byte_v[7]}}, byte_v};
      2'b01:   load_ext = {{(DATA_W-16){~f3_q[2] & half_v[15]}}, half_v};
      default: load_ext = bus.dm_rd;
    endcase
    merged = bus.dm_rd;
    if (f3_q[1:0] == 2'b00) merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                    merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          idx_q   <= bus.req_addr[DM_ADDRESS+1:2];
          lane_q  <= bus.req_addr[1:0];
          f3_q    <= bus.req_funct3;
          wdata_q <= bus.req_wdata;
          rdata_q <= '0;
          err_q   <= err_req;
        end
        S_LOAD:   rdata_q <= load_ext;
        S_RMW_RD: wdata_q <= merged;
        default: ;
      endcase
    end
  end

  // State resets to IDLE, so every output below is 0 while rst_n is low.
  always_comb begin
    bus.req_ready   = rst_n && (state_q == S_IDLE);
    bus.resp_valid  = (state_q == S_RESP);
    bus.resp_rdata  = (state_q == S_RESP) ? rdata_q : '0;
    bus.resp_err    = (state_q == S_RESP) && err_q;
    bus.dm_memread  = (state_q == S_LOAD)  || (state_q == S_RMW_RD);
    bus.dm_memwrite = (state_q == S_STORE) || (state_q == S_RMW_WR);
    bus.dm_a        = (state_q == S_IDLE) ? '0 : idx_q;
    bus.dm_wd       = bus.dm_memwrite ? wdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a behavioural data memory and a response scoreboard.
module tb_load_store_unit;
  localparam int DMA = 9;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.DM_ADDRESS(DMA), .DATA_W(DW)) bus ();

  load_store_unit #(.DM_ADDRESS(DMA), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [DW-1:0] mem [0:(1<<DMA)-1];
  assign bus.dm_rd = mem[bus.dm_a];
  always @(posedge clk) if (bus.dm_memwrite) mem[bus.dm_a] <= bus.dm_wd;

  typedef struct {
    logic           rd, wr;
    logic [2:0]     f3;
    logic [31:0]    addr, wdata, exp_rdata;
    logic           exp_err;
    int             exp_lat, exp_rd, exp_wr;
    logic [DMA-1:0] exp_a;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int lat, input int nrd, input int nwr,
                              input logic [DMA-1:0] exp_a);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = lat;
    v.exp_rd = nrd; v.exp_wr = nwr; v.exp_a = exp_a;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 10) begin @(negedge clk); w++; end
    check("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_read = v.rd; bus.req_write = v.wr;
    bus.req_funct3 = v.f3; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_funct3 = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int lat = 0, nrd = 0, nwr = 0, both = 0, abad = 0;
    logic got_resp = 1'b0;
    logic [31:0] rdata = '0;
    logic err = 1'b0;
    drive(v);
    sb.push_back(v);
    while (lat < 8 && !got_resp) begin
      @(negedge clk);
      lat++;
      if (bus.dm_memread)  nrd++;
      if (bus.dm_memwrite) nwr++;
      if (bus.dm_memread && bus.dm_memwrite) both++;
      if ((bus.dm_memread || bus.dm_memwrite) && bus.dm_a !== v.exp_a) abad++;
      if (bus.resp_valid) begin got_resp = 1'b1; rdata = bus.resp_rdata; err = bus.resp_err; end
    end
    check({tag, "_resp_seen"}, {31'b0, got_resp}, 32'd1);
    if (got_resp && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, lat, e.exp_lat);
      check({tag, "_rdata"}, rdata, e.exp_rdata);
      check({tag, "_err"}, {31'b0, err}, {31'b0, e.exp_err});
      check({tag, "_memread_cycles"}, nrd, e.exp_rd);
      check({tag, "_memwrite_cycles"}, nwr, e.exp_wr);
      check({tag, "_dm_a"}, abad, 0);
      check({tag, "_exclusive_strobes"}, both, 0);
      @(negedge clk);
      check({tag, "_resp_one_cycle"}, {31'b0, bus.resp_valid}, 32'd0);
      check({tag, "_back_to_idle"}, {31'b0, bus.req_ready}, 32'd1);
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   {31'b0, bus.req_ready}, 32'd0);
    check({tag, "_rvalid"},  {31'b0, bus.resp_valid}, 32'd0);
    check({tag, "_rdata"},   bus.resp_rdata, 32'd0);
    check({tag, "_err"},     {31'b0, bus.resp_err}, 32'd0);
    check({tag, "_memread"}, {31'b0, bus.dm_memread}, 32'd0);
    check({tag, "_memwrite"},{31'b0, bus.dm_memwrite}, 32'd0);
    check({tag, "_dm_a"},    {23'b0, bus.dm_a}, 32'd0);
    check({tag, "_dm_wd"},   bus.dm_wd, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1<<DMA); i++) mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_funct3 = '0; bus.req_addr = '0; bus.req_wdata = '0;

    //        rd  wr  f3      addr          wdata          exp_rdata     err lat rd wr a
    vecs.push_back(mk(0, 1, 3'b010, 32'h10,  32'h0000_0000, 32'h0,        0, 2, 0, 1, 9'd4));
    vecs.push_back(mk(0, 1, 3'b010, 32'h10,  32'hDEAD_BEEF, 32'h0,        0, 2, 0, 1, 9'd4));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10,  32'h0,         32'hDEAD_BEEF,0, 2, 1, 0, 9'd4));
    vecs.push_back(mk(0, 1, 3'b000, 32'h12,  32'hFFFF_FF5A, 32'h0,        0, 3, 1, 1, 9'd4));
    vecs.push_back(mk(1, 0, 3'b010, 32'h10,  32'h0,         32'hDE5A_BEEF,0, 2, 1, 0, 9'd4));
    vecs.push_back(mk(0, 1, 3'b010, 32'h20,  32'h0000_8081, 32'h0,        0, 2, 0, 1, 9'd8));
    vecs.push_back(mk(1, 0, 3'b000, 32'h20,  32'h0,         32'hFFFF_FF81,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b100, 32'h21,  32'h0,         32'h0000_0080,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b001, 32'h20,  32'h0,         32'hFFFF_8081,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b101, 32'h20,  32'h0,         32'h0000_8081,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b010, 32'h22,  32'h0,         32'h0,        1, 1, 0, 0, 9'd8));
    vecs.push_back(mk(0, 1, 3'b001, 32'h23,  32'hFFFF_FFFF, 32'h0,        1, 1, 0, 0, 9'd8));
    vecs.push_back(mk(1, 1, 3'b010, 32'h20,  32'hFFFF_FFFF, 32'h0,        1, 1, 0, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b011, 32'h20,  32'h0,         32'h0,        1, 1, 0, 0, 9'd8));
    vecs.push_back(mk(0, 1, 3'b100, 32'h20,  32'h1,         32'h0,        1, 1, 0, 0, 9'd8));
    vecs.push_back(mk(0, 0, 3'b010, 32'h20,  32'h1,         32'h0,        0, 1, 0, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b010, 32'h20,  32'h0,         32'h0000_8081,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(0, 1, 3'b001, 32'h22,  32'h5555_ABCD, 32'h0,        0, 3, 1, 1, 9'd8));
    vecs.push_back(mk(1, 0, 3'b010, 32'h20,  32'h0,         32'hABCD_8081,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b001, 32'h22,  32'h0,         32'hFFFF_ABCD,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(1, 0, 3'b100, 32'h23,  32'h0,         32'h0000_00AB,0, 2, 1, 0, 9'd8));
    vecs.push_back(mk(0, 1, 3'b010, 32'h804, 32'hCAFE_F00D, 32'h0,        0, 2, 0, 1, 9'd1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h004, 32'h0,         32'hCAFE_F00D,0, 2, 1, 0, 9'd1));
    vecs.push_back(mk(0, 1, 3'b010, 32'h30,  32'h5566_7788, 32'h0,        0, 2, 0, 1, 9'd12));

    #3;
    check_all_zero("in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // SH into word 12 with reset asserted while the merged word is being written
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_read = 1'b0; bus.req_write = 1'b1;
    bus.req_funct3 = 3'b001; bus.req_addr = 32'h30; bus.req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; bus.req_write = 1'b0;
    @(negedge clk);
    check("rmw_rd_strobe", {31'b0, bus.dm_memread}, 32'd1);
    @(negedge clk);
    check("rmw_wr_strobe", {31'b0, bus.dm_memwrite}, 32'd1);
    check("rmw_wr_data", bus.dm_wd, 32'h5566_1234);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_rmw_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_after_rmw_reset", {31'b0, bus.req_ready}, 32'd1);
    run_vec(mk(1, 0, 3'b010, 32'h30, 32'h0, 32'h5566_7788, 0, 2, 1, 0, 9'd12), "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
